data_mem_responder: RTL

//   Responder (memory) end of the CPU data-memory request/response protocol. The MEM

---
 rtl/mem_pkg.sv | 32 +++
 rtl/dmem_word_array.sv | 33 +++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types, widths and the address-window helper for the data-memory responder.
package mem_pkg;

   localparam int unsigned DMEM_WORD_W = 32;
   localparam int unsigned DMEM_BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_e;

   typedef struct packed {
      logic                   we;
      logic [31:0]            addr;
      logic [DMEM_WORD_W-1:0] wdata;
      logic [DMEM_BE_W-1:0]   be;
   } dmem_req_t;

   // True when addr lies outside [base, base + 4*depth) or is not word aligned.
   // The 33-bit difference makes addresses below base land above the window.
   function automatic logic dmem_addr_err(input logic [31:0]  addr,
                                          input logic [31:0]  base,
                                          input int unsigned  depth);
      logic [32:0] off;
      logic [32:0] span;
      off  = {1'b0, addr} - {1'b0, base};
      span = 33'(depth) << 2;
      return (off >= span) || (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/dmem_word_array.sv
// DEPTH x 32-bit word storage: byte-enabled synchronous write, registered read, no reset.
module dmem_word_array
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic                   re,
   input  logic [AW-1:0]          addr,
   input  logic [DMEM_WORD_W-1:0] wdata,
   input  logic [DMEM_BE_W-1:0]   be,
   output logic [DMEM_WORD_W-1:0] rdata
);

   logic [DMEM_WORD_W-1:0] mem [DEPTH];

   // Write only the enabled byte lanes; capture the addressed word on a read.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < int'(DMEM_BE_W); i++) begin
            if (be[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory request/response handshake.
// Accepts one request at a time, waits WAIT_STATES cycles, then pulses rsp_valid.
// Optional macro DMEM_ERR_CHECK_EN: flag out-of-window or misaligned requests via rsp_err,
// suppressing the store / zeroing the load data. Without it addresses alias modulo DEPTH.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);
   localparam bit          NO_WAIT   = (WAIT_STATES == 0);

   dmem_state_e state;
   dmem_req_t   req_q;
   dmem_req_t   sel;
   logic [3:0]  cnt;
   logic        err_q;
   logic        err_in;
   logic        err_sel;
   logic        accept;
   logic        fire;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] off;
   logic [AW-1:0] idx;
   logic [31:0] mem_rdata;
   logic        unused_off;

   assign accept = req_valid & req_ready;

`ifdef DMEM_ERR_CHECK_EN
   assign err_in  = dmem_addr_err(req_addr, BASE_ADDR, DEPTH);
   assign rsp_err = rsp_valid & err_q;
`else
   assign err_in  = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // Request FSM: IDLE accepts, WAIT counts down, RESP pulses the response for one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         cnt       <= 4'd0;
         req_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  req_q     <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
                  err_q     <= err_in;
                  req_ready <= 1'b0;
                  if (NO_WAIT) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end else begin
                     state <= WAIT;
                     cnt   <= WAIT_LOAD;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b0;
            end
         endcase
      end
   end

   // Array access fires on the edge entering RESP; with no wait states that is the accept
   // edge itself, so the live request is used instead of the not-yet-latched copy.
   always_comb begin
      sel     = req_q;
      err_sel = err_q;
      fire    = 1'b0;
      if (state == IDLE) begin
         sel     = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
         err_sel = err_in;
         fire    = accept & NO_WAIT;
      end else if (state == WAIT) begin
         fire = (cnt == 4'd0);
      end
   end

   assign mem_we     = fire & sel.we & ~err_sel;
   assign mem_re     = fire & ~sel.we & ~err_sel;
   assign off        = sel.addr - BASE_ADDR;
   assign idx        = off[AW+1:2];
   assign unused_off = ^off;

   // Load data is only presented during the response strobe, and never for stores/errors.
   assign rsp_rdata = (rsp_valid && !req_q.we && !err_q) ? mem_rdata : 32'h0;

   dmem_word_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (idx),
      .wdata (sel.wdata),
      .be    (sel.be),
      .rdata (mem_rdata)
   );

endmodule
